// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel timer: channel state encoding,
// default parameter values and the cycle-counter width helper.
package multi_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } ch_state_t;

    localparam int DEF_N_CH           = 4;
    localparam int DEF_LEN_W          = 32;
    localparam int DEF_TICKS_PER_UNIT = 50000000;

    // Width of a counter spanning 0..ticks-1; never narrower than one bit.
    function automatic int cyc_width(input int ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One independent timer channel: IDLE/RUN/PAUSED FSM with its own unit
// prescaler, latched length and mode, and registered status outputs.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int LEN_W          = DEF_LEN_W,
    parameter int TICKS_PER_UNIT = DEF_TICKS_PER_UNIT
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             periodic,
    input  logic [LEN_W-1:0] length,
    output logic             active,
    output logic             done,
    output logic [LEN_W-1:0] remaining
);

    localparam int               CYC_W    = cyc_width(TICKS_PER_UNIT);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TICKS_PER_UNIT - 1);

    ch_state_t        state_reg, state_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic             mode_reg, mode_next;
    logic [LEN_W-1:0] rem_reg, rem_next;
    logic [CYC_W-1:0] cyc_reg, cyc_next;
    logic             done_reg, done_next;
    logic             active_reg;

    // State and datapath registers; reset aborts silently and ignores inputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg  <= ST_IDLE;
            len_reg    <= '0;
            mode_reg   <= 1'b0;
            rem_reg    <= '0;
            cyc_reg    <= '0;
            done_reg   <= 1'b0;
            active_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            len_reg    <= len_next;
            mode_reg   <= mode_next;
            rem_reg    <= rem_next;
            cyc_reg    <= cyc_next;
            done_reg   <= done_next;
            active_reg <= (state_next != ST_IDLE);
        end
    end

    // Next-state logic with priority stop > start > pause. Counting happens
    // on any edge where the channel is live and pause is low, so the edge
    // leaving PAUSED already advances the frozen cycle count.
    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        mode_next  = mode_reg;
        rem_next   = rem_reg;
        cyc_next   = cyc_reg;
        done_next  = 1'b0;

        if (stop) begin
            state_next = ST_IDLE;
            rem_next   = '0;
            cyc_next   = '0;
        end else if (start) begin
            cyc_next = '0;
            if (length == '0) begin
                // Zero-length request expires immediately.
                state_next = ST_IDLE;
                rem_next   = '0;
                done_next  = 1'b1;
            end else begin
                len_next   = length;
                mode_next  = periodic;
                rem_next   = length;
                state_next = (state_reg == ST_PAUSED && pause) ? ST_PAUSED : ST_RUN;
            end
        end else if (state_reg != ST_IDLE) begin
            if (pause) begin
                state_next = ST_PAUSED;
            end else begin
                state_next = ST_RUN;
                if (cyc_reg == CYC_LAST) begin
                    cyc_next = '0;
                    if (rem_reg == LEN_W'(1)) begin
                        done_next = 1'b1;
                        if (mode_reg) begin
                            rem_next = len_reg;
                        end else begin
                            rem_next   = '0;
                            state_next = ST_IDLE;
                        end
                    end else if (rem_reg > LEN_W'(1)) begin
                        rem_next = rem_reg - LEN_W'(1);
                    end
                end else begin
                    cyc_next = cyc_reg + CYC_W'(1);
                end
            end
        end
    end

    assign active    = active_reg;
    assign done      = done_reg;
    assign remaining = rem_reg;

endmodule

// File: rtl/multi_timer.sv
// Bank of N_CH independent timers; each channel has its own prescaler so
// its first unit is always a full TICKS_PER_UNIT cycles.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int N_CH           = DEF_N_CH,
    parameter int LEN_W          = DEF_LEN_W,
    parameter int TICKS_PER_UNIT = DEF_TICKS_PER_UNIT
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [N_CH-1:0]       start,
    input  logic [N_CH-1:0]       stop,
    input  logic [N_CH-1:0]       pause,
    input  logic [N_CH-1:0]       periodic,
    input  logic [N_CH*LEN_W-1:0] timer_length,
    output logic [N_CH-1:0]       active,
    output logic [N_CH-1:0]       done,
    output logic [N_CH*LEN_W-1:0] remaining
);

    // One channel per bit; length and remaining are packed LEN_W per channel.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            timer_channel #(
                .LEN_W          (LEN_W),
                .TICKS_PER_UNIT (TICKS_PER_UNIT)
            ) u_ch (
                .clock     (clock),
                .resetn    (resetn),
                .start     (start[gi]),
                .stop      (stop[gi]),
                .pause     (pause[gi]),
                .periodic  (periodic[gi]),
                .length    (timer_length[gi*LEN_W +: LEN_W]),
                .active    (active[gi]),
                .done      (done[gi]),
                .remaining (remaining[gi*LEN_W +: LEN_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_timer.sv
// Directed self-checking bench for multi_timer (4 channels, 8-bit lengths,
// 4 cycles per unit). Edge 0 is the edge that samples the start strobe.
module tb_multi_timer;

    localparam int N_CH = 4;
    localparam int LW   = 8;
    localparam int TPU  = 4;

    logic              clock = 1'b0;
    logic              resetn;
    logic [N_CH-1:0]   start, stop, pause, periodic;
    logic [N_CH*LW-1:0] timer_length;
    logic [N_CH-1:0]   active, done;
    logic [N_CH*LW-1:0] remaining;

    int passed = 0;
    int total  = 0;

    multi_timer #(.N_CH(N_CH), .LEN_W(LW), .TICKS_PER_UNIT(TPU)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .start        (start),
        .stop         (stop),
        .pause        (pause),
        .periodic     (periodic),
        .timer_length (timer_length),
        .active       (active),
        .done         (done),
        .remaining    (remaining)
    );

    always #5 clock = ~clock;

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulse start on one channel; returns just after edge 0.
    task automatic launch(input int ch, input logic [LW-1:0] len, input logic per);
        start[ch]              = 1'b1;
        periodic[ch]           = per;
        timer_length[ch*LW +: LW] = len;
        tick();
        start[ch] = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start = '0; stop = '0; pause = '0; periodic = '0; timer_length = '0;
        tick();
        start[0] = 1'b1; timer_length[7:0] = 8'd3;   // must be ignored in reset
        tick();
        start = '0;
        total++; if (active !== 4'b0) $display("FAIL reset_active got=%b exp=%b", active, 4'b0); else passed++;
        total++; if (done !== 4'b0) $display("FAIL reset_done got=%b exp=%b", done, 4'b0); else passed++;
        total++; if (remaining !== 32'h0) $display("FAIL reset_remaining got=%h exp=%h", remaining, 32'h0); else passed++;
        resetn = 1'b1;
        tick();
        total++; if (active !== 4'b0) $display("FAIL reset_release_active got=%b exp=%b", active, 4'b0); else passed++;
        $display("test_reset done");
    endtask

    task automatic test_oneshot();
        int exp_rem;
        launch(0, 8'd3, 1'b0);
        for (int k = 0; k <= 14; k++) begin
            exp_rem = (k >= 12) ? 0 : 3 - k / TPU;
            total++; if (active[0] !== (k < 12)) $display("FAIL oneshot_active k=%0d got=%b exp=%b", k, active[0], (k < 12)); else passed++;
            total++; if (done[0] !== (k == 12)) $display("FAIL oneshot_done k=%0d got=%b exp=%b", k, done[0], (k == 12)); else passed++;
            total++; if (remaining[7:0] !== 8'(exp_rem)) $display("FAIL oneshot_rem k=%0d got=%0d exp=%0d", k, remaining[7:0], exp_rem); else passed++;
            tick();
        end
        $display("test_oneshot done");
    endtask

    task automatic test_periodic();
        int exp_rem;
        launch(1, 8'd2, 1'b1);
        for (int k = 0; k <= 30; k++) begin
            exp_rem = (k >= 26) ? 0 : 2 - (k % 8) / TPU;
            total++; if (done[1] !== (k == 8 || k == 16 || k == 24)) $display("FAIL periodic_done k=%0d got=%b", k, done[1]); else passed++;
            total++; if (active[1] !== (k < 26)) $display("FAIL periodic_active k=%0d got=%b exp=%b", k, active[1], (k < 26)); else passed++;
            total++; if (remaining[15:8] !== 8'(exp_rem)) $display("FAIL periodic_rem k=%0d got=%0d exp=%0d", k, remaining[15:8], exp_rem); else passed++;
            stop[1] = (k == 25);
            tick();
        end
        stop[1] = 1'b0;
        $display("test_periodic done");
    endtask

    task automatic test_pause();
        int e, exp_rem;
        launch(2, 8'd5, 1'b0);
        for (int k = 0; k <= 32; k++) begin
            e       = (k <= 5) ? k : ((k <= 15) ? 5 : k - 10);
            exp_rem = (k >= 30) ? 0 : 5 - e / TPU;
            total++; if (done[2] !== (k == 30)) $display("FAIL pause_done k=%0d got=%b exp=%b", k, done[2], (k == 30)); else passed++;
            total++; if (active[2] !== (k < 30)) $display("FAIL pause_active k=%0d got=%b exp=%b", k, active[2], (k < 30)); else passed++;
            total++; if (remaining[23:16] !== 8'(exp_rem)) $display("FAIL pause_rem k=%0d got=%0d exp=%0d", k, remaining[23:16], exp_rem); else passed++;
            pause[2] = (k >= 5 && k <= 14);   // sampled at edges 6..15
            tick();
        end
        pause[2] = 1'b0;
        $display("test_pause done");
    endtask

    task automatic test_zero_len();
        launch(3, 8'd0, 1'b0);
        total++; if (done !== 4'b1000) $display("FAIL zero_done_pulse got=%b exp=%b", done, 4'b1000); else passed++;
        total++; if (active[3] !== 1'b0) $display("FAIL zero_active got=%b exp=0", active[3]); else passed++;
        pause[3] = 1'b1;   // pause in IDLE has no effect
        tick();
        total++; if (done[3] !== 1'b0) $display("FAIL zero_done_after got=%b exp=0", done[3]); else passed++;
        tick();
        total++; if (active[3] !== 1'b0) $display("FAIL zero_pause_idle got=%b exp=0", active[3]); else passed++;
        pause[3] = 1'b0;
        // Simultaneous stop and start: stop wins.
        launch(0, 8'd3, 1'b0);
        tick(); tick();
        stop[0] = 1'b1; start[0] = 1'b1;
        tick();
        stop[0] = 1'b0; start[0] = 1'b0;
        total++; if (active[0] !== 1'b0) $display("FAIL stopstart_active got=%b exp=0", active[0]); else passed++;
        total++; if (remaining[7:0] !== 8'd0) $display("FAIL stopstart_rem got=%0d exp=0", remaining[7:0]); else passed++;
        for (int k = 0; k < 14; k++) begin
            total++; if (done[0] !== 1'b0) $display("FAIL stopstart_done k=%0d got=%b exp=0", k, done[0]); else passed++;
            tick();
        end
        $display("test_zero_len done");
    endtask

    task automatic test_collision();
        // Stop on the expiry edge suppresses done.
        launch(0, 8'd1, 1'b0);
        tick(); tick(); tick();
        stop[0] = 1'b1;
        tick();
        stop[0] = 1'b0;
        total++; if (done[0] !== 1'b0) $display("FAIL coll_stop_done got=%b exp=0", done[0]); else passed++;
        total++; if (active[0] !== 1'b0) $display("FAIL coll_stop_active got=%b exp=0", active[0]); else passed++;
        tick();
        total++; if (done[0] !== 1'b0) $display("FAIL coll_stop_late got=%b exp=0", done[0]); else passed++;
        // Restart on the expiry edge suppresses done and reloads.
        launch(0, 8'd1, 1'b0);
        tick(); tick(); tick();
        launch(0, 8'd2, 1'b0);
        total++; if (done[0] !== 1'b0) $display("FAIL coll_start_done got=%b exp=0", done[0]); else passed++;
        total++; if (active[0] !== 1'b1) $display("FAIL coll_start_active got=%b exp=1", active[0]); else passed++;
        total++; if (remaining[7:0] !== 8'd2) $display("FAIL coll_start_rem got=%0d exp=2", remaining[7:0]); else passed++;
        for (int k = 1; k <= 10; k++) begin
            tick();
            total++; if (done[0] !== (k == 8)) $display("FAIL coll_restart_done k=%0d got=%b exp=%b", k, done[0], (k == 8)); else passed++;
        end
        $display("test_collision done");
    endtask

    task automatic test_reset_midcount();
        start = 4'hF; periodic = 4'hF; timer_length = {4{8'd3}};
        tick();
        start = '0;
        for (int k = 0; k < 5; k++) tick();
        total++; if (active !== 4'hF) $display("FAIL mid_all_running got=%b exp=%b", active, 4'hF); else passed++;
        resetn = 1'b0; start[1] = 1'b1;
        tick();
        resetn = 1'b1; start = '0; periodic = '0;
        total++; if (active !== 4'b0) $display("FAIL mid_reset_active got=%b exp=0000", active); else passed++;
        total++; if (done !== 4'b0) $display("FAIL mid_reset_done got=%b exp=0000", done); else passed++;
        total++; if (remaining !== 32'h0) $display("FAIL mid_reset_rem got=%h exp=0", remaining); else passed++;
        for (int k = 0; k < 13; k++) begin
            tick();
            total++; if ((done | active) !== 4'b0) $display("FAIL mid_after_reset k=%0d got=%b exp=0000", k, done | active); else passed++;
        end
        launch(0, 8'd1, 1'b0);
        for (int k = 0; k <= 6; k++) begin
            total++; if (done !== ((k == 4) ? 4'b0001 : 4'b0000)) $display("FAIL mid_restart_done k=%0d got=%b", k, done); else passed++;
            total++; if (active[0] !== (k < 4)) $display("FAIL mid_restart_active k=%0d got=%b exp=%b", k, active[0], (k < 4)); else passed++;
            tick();
        end
        $display("test_reset_midcount done");
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause();
        test_zero_len();
        test_collision();
        test_reset_midcount();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
